// File: rtl/sram_pkg.sv
// sram_pkg
// Shared constants for the 32x128 single-port SRAM model and its write-count trigger.
//   DATA_WIDTH / ADDR_WIDTH / RAM_DEPTH : memory geometry
//   CNT_WIDTH                           : width of the write counter
//   TRIG_COUNT                          : counter value at which writes start storing ~data
//   CNT_MAX                             : saturation value of the write counter
package sram_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH  = 8;

    localparam logic [CNT_WIDTH-1:0] TRIG_COUNT = 8'hFF;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

endpackage

// File: rtl/sram_wr_trigger.sv
// sram_wr_trigger
// Counts accepted writes since the last reset (saturating) and flags when the
// count has reached the trigger value, at which point writes are inverted.
// Ports:
//   clk0      in   clock, rising edge
//   rst0      in   synchronous active-high reset, clears the count
//   wr_strobe in   one accepted write this cycle
//   count     out  current (pre-edge) write count
//   invert    out  high when the current write must store inverted data
module sram_wr_trigger
    import sram_pkg::*;
#(
    parameter logic [CNT_WIDTH-1:0] TRIG = TRIG_COUNT
) (
    input  logic                 clk0,
    input  logic                 rst0,
    input  logic                 wr_strobe,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 invert
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            count_q <= '0;
        end else if (wr_strobe && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Compare uses the pre-edge count, so the write that sees TRIG is itself inverted.
    always_comb begin
        invert = (count_q == TRIG);
    end

    assign count = count_q;

endmodule

// File: rtl/sram_32x128_1rw.sv
// sram_32x128_1rw
// Single-port 32x128 synchronous SRAM with active-low chip select / write enable
// and an internal write-count trigger: once TRIG_COUNT writes have been accepted
// since reset, every further write stores the bitwise inverse of its data.
// Ports:
//   clk0   in   clock, all state updates on rising edge
//   rst0   in   synchronous active-high reset (clears dout0 and counter, not memory)
//   csb0   in   chip select, active low
//   web0   in   write enable, active low (1 = read)
//   addr0  in   word address
//   din0   in   write data
//   dout0  out  registered read data, 1-cycle latency
module sram_32x128_1rw
    import sram_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int unsigned          ADDR_WIDTH = sram_pkg::ADDR_WIDTH,
    parameter int unsigned          RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [CNT_WIDTH-1:0] TRIG_COUNT = sram_pkg::TRIG_COUNT
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [CNT_WIDTH-1:0]  trojan_counter;
    logic                  invert;
    logic                  wr_strobe;
    logic                  rd_strobe;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_strobe = ~csb0 & ~web0;
        rd_strobe = ~csb0 & web0;
        wr_data   = invert ? ~din0 : din0;
    end

    sram_wr_trigger #(
        .TRIG(TRIG_COUNT)
    ) u_wr_trigger (
        .clk0     (clk0),
        .rst0     (rst0),
        .wr_strobe(wr_strobe),
        .count    (trojan_counter),
        .invert   (invert)
    );

    // Array has no reset; reset only blocks the write.
    always_ff @(posedge clk0) begin
        if (!rst0 && wr_strobe) begin
            mem[addr0] <= wr_data;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0 <= '0;
        end else if (rd_strobe) begin
            dout0 <= mem[addr0];
        end
    end

endmodule

// File: tb/tb_sram_32x128_1rw.sv
module tb_sram_32x128_1rw;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        csb0;
    logic        web0;
    logic [6:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    int tests = 0;
    int fails = 0;

    // Reference model: plain memory image, unbounded write count since reset.
    logic [31:0] ref_mem [128];
    bit          ref_valid [128];
    int          ref_writes;
    logic [31:0] ref_dout;
    logic [6:0]  last_wr_addr;
    logic [31:0] held;

    always #5 clk0 = ~clk0;

    sram_32x128_1rw dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .csb0 (csb0),
        .web0 (web0),
        .addr0(addr0),
        .din0 (din0),
        .dout0(dout0)
    );

    function automatic logic [7:0] ref_count();
        return (ref_writes > 255) ? 8'hFF : 8'(ref_writes);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive on falling edge, sample 1 ns after rising edge, then check.
    task automatic cycle(input logic r, input logic c, input logic w,
                         input logic [6:0] a, input logic [31:0] d);
        @(negedge clk0);
        rst0  = r;
        csb0  = c;
        web0  = w;
        addr0 = a;
        din0  = d;
        @(posedge clk0);
        #1;
        if (r) begin
            ref_dout   = '0;
            ref_writes = 0;
        end else if (!c && !w) begin
            ref_mem[a]   = (ref_writes >= 255) ? ~d : d;
            ref_valid[a] = 1'b1;
            ref_writes++;
            last_wr_addr = a;
        end else if (!c && w) begin
            ref_dout = ref_mem[a];
        end
        check("dout0", dout0, ref_dout);
        check("trojan_counter", {24'h0, dut.trojan_counter}, {24'h0, ref_count()});
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [6:0] a);
        cycle(1'b0, 1'b0, 1'b1, a, $urandom);
    endtask

    function automatic logic [6:0] pick_valid();
        logic [6:0] a;
        for (int i = 0; i < 1000; i++) begin
            a = 7'($urandom_range(0, 127));
            if (ref_valid[a]) return a;
        end
        return last_wr_addr;
    endfunction

    initial begin
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0;
        ref_writes = 0; ref_dout = '0; last_wr_addr = 7'd0;
        for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;

        // Reset state
        do_reset();
        check("reset_dout", dout0, 32'h0);
        check("reset_cnt", {24'h0, dut.trojan_counter}, 32'h0);

        // Basic write/read
        wr(7'd10, 32'hFACECAFE);
        rd(7'd10);
        check("rd_facecafe", dout0, 32'hFACECAFE);

        // Counter tracking
        do_reset();
        for (int i = 0; i < 10; i++) wr(7'd10, 32'hDEADBEEF);
        check("cnt_10", {24'h0, dut.trojan_counter}, 32'h0000000A);
        rd(7'd10);
        check("rd_deadbeef", dout0, 32'hDEADBEEF);

        // A write request during reset must not land
        cycle(1'b1, 1'b0, 1'b0, 7'd10, 32'h0BADF00D);
        rd(7'd10);
        check("no_wr_in_reset", dout0, 32'hDEADBEEF);

        // Trigger: 255 true writes, then inversion
        do_reset();
        for (int i = 0; i < 255; i++) begin
            wr(7'($urandom_range(0, 127)), $urandom);
            if ((i % 8) == 0) rd(pick_valid());
        end
        check("cnt_ff", {24'h0, dut.trojan_counter}, 32'h000000FF);
        rd(last_wr_addr);
        wr(7'd12, 32'hDEADBEEF);
        rd(7'd12);
        check("rd_inverted", dout0, 32'h21524110);
        for (int i = 0; i < 20; i++) begin
            wr(7'($urandom_range(13, 127)), $urandom);
            rd(pick_valid());
        end
        check("cnt_sat", {24'h0, dut.trojan_counter}, 32'h000000FF);

        // Deselect: no write, dout0 and counter hold
        rd(7'd10);
        held = dout0;
        cycle(1'b0, 1'b1, 1'b0, 7'd10, 32'h12345678);
        check("desel_hold", dout0, held);
        cycle(1'b0, 1'b1, 1'b1, 7'd12, 32'h0);
        check("idle_hold", dout0, held);
        rd(7'd10);

        // Reset mid-sequence
        do_reset();
        for (int i = 0; i < 200; i++) wr(7'($urandom_range(64, 119)), $urandom);
        check("cnt_200", {24'h0, dut.trojan_counter}, 32'h000000C8);
        do_reset();
        check("cnt_rst_mid", {24'h0, dut.trojan_counter}, 32'h0);
        wr(7'd120, 32'hA5A5A5A5);
        rd(7'd120);
        check("rd_a5_true", dout0, 32'hA5A5A5A5);
        rd(7'd12);
        check("preserved_12", dout0, 32'h21524110);
        for (int i = 0; i < 30; i++) rd(pick_valid());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
